fir_out_requant: RTL and testbench



---
 rtl/fir_out_requant_pkg.sv | 26 ++
 rtl/fir_out_requant_if.sv | 35 +++
 rtl/fir_round_sat.sv | 40 ++++
 rtl/fir_out_requant.sv | 117 +++++++++++
 tb/tb_fir_out_requant.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fir_out_requant_pkg.sv
// Shared constants for the FIR output requantizer: widths, decimation select codes,
// FSM state codes and the decimation log2 helper.
package fir_out_requant_pkg;

  localparam int Y_N_SIZE = 14;
  localparam int OUT_SIZE = 8;
  localparam int SHIFT    = 6;
  localparam int ACC_SIZE = Y_N_SIZE + 3;
  localparam int T_W      = 4;

  localparam logic [T_W-1:0] SHIFT_T = T_W'(SHIFT);

  localparam logic [1:0] DECIM_1 = 2'b00;
  localparam logic [1:0] DECIM_2 = 2'b01;
  localparam logic [1:0] DECIM_4 = 2'b10;
  localparam logic [1:0] DECIM_8 = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // The select code is already the exponent of the decimation factor.
  function automatic logic [1:0] decim_log2(input logic [1:0] sel);
    return sel;
  endfunction

endpackage

// File: rtl/fir_out_requant_if.sv
// Sample/result bundle between the FIR filter, the requantizer and the output pins.
// Optional sat_flag present when FIR_OUT_REQUANT_SAT_FLAG_EN is defined.
interface fir_out_requant_if;
  import fir_out_requant_pkg::*;

  // Valid-only protocol: y_n is consumed in every cycle in_valid is high (no ready);
  // q_valid is a one-cycle strobe marking a new q_out word.
  logic signed [Y_N_SIZE-1:0] y_n;
  logic                       in_valid;
  logic [1:0]                 decim_sel;
  logic                       flush;
  logic signed [OUT_SIZE-1:0] q_out;
  logic                       q_valid;
  logic [0:0]                 dbg_state;
`ifdef FIR_OUT_REQUANT_SAT_FLAG_EN
  logic                       sat_flag;
`endif

  modport master (
    output y_n, in_valid, decim_sel, flush,
`ifdef FIR_OUT_REQUANT_SAT_FLAG_EN
    input  sat_flag,
`endif
    input  q_out, q_valid, dbg_state
  );

  modport slave (
    input  y_n, in_valid, decim_sel, flush,
`ifdef FIR_OUT_REQUANT_SAT_FLAG_EN
    output sat_flag,
`endif
    output q_out, q_valid, dbg_state
  );

endinterface

// File: rtl/fir_round_sat.sv
// Combinational round-half-up arithmetic right shift followed by saturation to OUT_W bits.
module fir_round_sat #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 8,
  parameter int T_W   = 4
) (
  input  logic signed [IN_W-1:0]  acc_i,
  input  logic        [T_W-1:0]   shift_i,
  output logic signed [OUT_W-1:0] q_o,
  output logic                    clip_o
);

  // One guard bit so adding the rounding constant to a full-scale sum cannot wrap.
  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] half;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] shd;

  always_comb begin
    ext  = {acc_i[IN_W-1], acc_i};
    half = '0;
    if (shift_i != '0) half = EW'(1) << (shift_i - 1'b1);
    rnd    = ext + half;
    shd    = rnd >>> shift_i;
    q_o    = shd[OUT_W-1:0];
    clip_o = 1'b0;
    if (shd > MAX_V) begin
      q_o    = MAX_V[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (shd < MIN_V) begin
      q_o    = MIN_V[OUT_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// Accumulate-and-dump decimator with round/saturate to the 8-bit output pins.
// FIR_OUT_REQUANT_SAT_FLAG_EN adds a sticky sat_flag output.
module fir_out_requant
  import fir_out_requant_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fir_out_requant_if.slave  bus
);

  logic [0:0]                 state_q, state_d;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [1:0]                 d_sel_q, d_sel_d;
  logic signed [OUT_SIZE-1:0] q_out_q, q_out_d;
  logic                       q_valid_q, q_valid_d;

  logic signed [ACC_SIZE-1:0] samp_ext;
  logic signed [ACC_SIZE-1:0] sum;
  logic [1:0]                 sel_eff;
  logic [T_W-1:0]             shift_t;
  logic                       last;
  logic                       dump;
  logic signed [OUT_SIZE-1:0] rs_q;
  logic                       clip;

  // acc is zero in IDLE, so one adder serves both the first and later samples.
  always_comb begin
    samp_ext = {{(ACC_SIZE-Y_N_SIZE){bus.y_n[Y_N_SIZE-1]}}, bus.y_n};
    sum      = acc_q + samp_ext;
    sel_eff  = (state_q == ST_IDLE) ? bus.decim_sel : d_sel_q;
    shift_t  = {2'b00, decim_log2(sel_eff)} + SHIFT_T;
    last     = (({1'b0, cnt_q} + 4'd1) == (4'd1 << sel_eff));
    dump     = bus.in_valid && last && !bus.flush;
  end

  fir_round_sat #(
    .IN_W  (ACC_SIZE),
    .OUT_W (OUT_SIZE),
    .T_W   (T_W)
  ) u_round_sat (
    .acc_i   (sum),
    .shift_i (shift_t),
    .q_o     (rs_q),
    .clip_o  (clip)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    d_sel_d   = d_sel_q;
    q_out_d   = q_out_q;
    q_valid_d = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (bus.in_valid) begin
      if (state_q == ST_IDLE) d_sel_d = bus.decim_sel;
      if (last) begin
        state_d   = ST_IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        q_out_d   = rs_q;
        q_valid_d = 1'b1;
      end else begin
        state_d = ST_ACCUM;
        acc_d   = sum;
        cnt_d   = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      d_sel_q   <= DECIM_1;
      q_out_q   <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      d_sel_q   <= d_sel_d;
      q_out_q   <= q_out_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.q_out     = q_out_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.dbg_state = state_q;

`ifdef FIR_OUT_REQUANT_SAT_FLAG_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (bus.flush)  sat_d = 1'b0;
    else if (dump)  sat_d = sat_q | clip;
  end

  always_ff @(posedge clk) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign bus.sat_flag = sat_q;
`else
  logic unused_clip;
  assign unused_clip = clip ^ dump;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant: directed test-plan cases plus random traffic,
// with a scoreboard queue of expected output words. Honors FIR_OUT_REQUANT_SAT_FLAG_EN.
module tb_fir_out_requant;
  import fir_out_requant_pkg::*;

  logic clk;
  logic reset;
  fir_out_requant_if bus();

  fir_out_requant dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       exp_sat_q[$];
  logic [7:0] last_exp = 8'd0;

  int m_acc = 0;
  int m_cnt = 0;
  int m_d   = 1;
  bit m_sat = 1'b0;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] req(input int s, input int d, output bit clip);
    int t;
    int r;
    t = SHIFT;
    for (int k = d; k > 1; k = k / 2) t++;
    r = (s + (1 << (t - 1))) >>> t;
    clip = 1'b0;
    if (r > 127)  begin r = 127;  clip = 1'b1; end
    if (r < -128) begin r = -128; clip = 1'b1; end
    return r[7:0];
  endfunction

  // driver tasks
  task automatic drive(input int y, input bit v, input logic [1:0] sel, input bit fl);
    bit c;
    logic [7:0] e;
    @(posedge clk); #1;
    bus.y_n       = y[Y_N_SIZE-1:0];
    bus.in_valid  = v;
    bus.decim_sel = sel;
    bus.flush     = fl;
    if (fl) begin
      m_acc = 0; m_cnt = 0; m_sat = 1'b0;
    end else if (v) begin
      if (m_cnt == 0) m_d = 1 << sel;
      m_acc += y;
      m_cnt++;
      if (m_cnt == m_d) begin
        e = req(m_acc, m_d, c);
        m_sat = m_sat | c;
        exp_q.push_back(e);
        exp_sat_q.push_back(m_sat);
        m_acc = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive($urandom_range(0, 16383) - 8192, 1'b0, bus.decim_sel, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    m_acc = 0; m_cnt = 0; m_sat = 1'b0; last_exp = 8'd0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!reset && bus.q_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 8'd1, 8'd0);
      end else begin
        last_exp = exp_q.pop_front();
        chk("q_out", bus.q_out, last_exp);
`ifdef FIR_OUT_REQUANT_SAT_FLAG_EN
        chk("sat_flag", {7'd0, bus.sat_flag}, {7'd0, exp_sat_q.pop_front()});
`else
        void'(exp_sat_q.pop_front());
`endif
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.y_n       = '0;
    bus.in_valid  = 1'b0;
    bus.decim_sel = DECIM_1;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_q_out", bus.q_out, 8'd0);
    chk("rst_q_valid", {7'd0, bus.q_valid}, 8'd0);
    chk("rst_state", {7'd0, bus.dbg_state}, {7'd0, ST_IDLE});

    // D=1 rounding and saturation
    drive(100, 1'b1, DECIM_1, 1'b0);  idle(2);
    chk("d1_pos", bus.q_out, 8'd2);
`ifdef FIR_OUT_REQUANT_SAT_FLAG_EN
    chk("sat_pre", {7'd0, bus.sat_flag}, 8'd0);
`endif
    drive(-100, 1'b1, DECIM_1, 1'b0); idle(2);
    chk("d1_neg", bus.q_out, 8'hFE);
    drive(8191, 1'b1, DECIM_1, 1'b0); idle(2);
    chk("d1_satp", bus.q_out, 8'h7F);
    drive(-8192, 1'b1, DECIM_1, 1'b0); idle(2);
    chk("d1_min", bus.q_out, 8'h80);
`ifdef FIR_OUT_REQUANT_SAT_FLAG_EN
    chk("sat_post", {7'd0, bus.sat_flag}, 8'd1);
`endif

    // D=4 with random gaps
    for (int i = 0; i < 4; i++) begin
      drive(64, 1'b1, DECIM_4, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(2);
    chk("d4_64", bus.q_out, 8'd1);

    // decim_sel change mid-block only affects the next block
    drive(200, 1'b1, DECIM_2, 1'b0);
    drive(200, 1'b1, DECIM_8, 1'b0);
    idle(2);
    chk("d2_mid", bus.q_out, 8'd3);
    for (int i = 0; i < 8; i++) drive(1000, 1'b1, DECIM_8, 1'b0);
    idle(2);
    chk("d8_next", bus.q_out, 8'd16);

    // flush drops the partial block
    drive(300, 1'b1, DECIM_4, 1'b0);
    drive(300, 1'b1, DECIM_4, 1'b0);
    drive(300, 1'b1, DECIM_4, 1'b1);
    idle(3);
    chk("flush_hold", bus.q_out, last_exp);
    for (int i = 0; i < 4; i++) drive(256, 1'b1, DECIM_4, 1'b0);
    idle(2);
    chk("after_flush", bus.q_out, 8'd4);

    // reset mid-block
    for (int i = 0; i < 5; i++) drive(700, 1'b1, DECIM_8, 1'b0);
    do_reset();
    @(negedge clk);
    chk("mid_rst_q", bus.q_out, 8'd0);
    chk("mid_rst_v", {7'd0, bus.q_valid}, 8'd0);
    for (int i = 0; i < 8; i++) drive(500, 1'b1, DECIM_8, 1'b0);
    idle(2);
    chk("post_rst", bus.q_out, 8'd8);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 16383) - 8192, ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
    end
    drive(0, 1'b0, DECIM_1, 1'b1);
    idle(5);
    chk("drain", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
